// File: rtl/sump_cmd_ctrl.sv
// SUMP command framer: turns the UART byte stream into short/long command strobes
// with a stable opcode and little-endian argument; truncated long commands time out.
module sump_cmd_ctrl #(
    parameter  int DATA_BITS       = 8,
    parameter  int CMD_WIDTH_WORDS = 5,
    parameter  int TIMEOUT_CLKS    = 100000,
    localparam int ARG_W           = (CMD_WIDTH_WORDS - 1) * DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic [DATA_BITS-1:0] cmd_o,
    output logic [ARG_W-1:0]     arg_o,
    output logic                 short_stb_o,
    output logic                 long_stb_o,
    output logic                 timeout_o,
    output logic                 busy_o,
    output logic                 state_o
);

    // Handshake: valid_i is a one-cycle strobe with no ready; every strobed word
    // is consumed in the cycle it is presented. Strobe outputs are one-cycle pulses.

    localparam int ARG_WORDS = CMD_WIDTH_WORDS - 1;
    localparam int IDX_W     = (CMD_WIDTH_WORDS > 2) ? $clog2(CMD_WIDTH_WORDS) : 1;
    localparam int CNT_W     = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CMD_WIDTH_WORDS - 2);
    localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CLKS - 2);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] pend_q;
    logic [ARG_W-1:0]     asm_q;
    logic [ARG_W-1:0]     asm_nxt;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q;

    logic short_evt;
    logic open_evt;
    logic arg_evt;
    logic long_evt;
    logic to_evt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid_i && data_i[DATA_BITS-1]) begin
                    state_nxt = ARG;
                end
            end
            ARG: begin
                if (valid_i) begin
                    if (idx_q == IDX_LAST) begin
                        state_nxt = IDLE;
                    end
                end else if (cnt_q == CNT_EXPIRE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        short_evt = (state == IDLE) && valid_i && !data_i[DATA_BITS-1];
        open_evt  = (state == IDLE) && valid_i && data_i[DATA_BITS-1];
        arg_evt   = (state == ARG) && valid_i;
        long_evt  = arg_evt && (idx_q == IDX_LAST);
        to_evt    = (state == ARG) && !valid_i && (cnt_q == CNT_EXPIRE);
    end

    always_comb begin
        asm_nxt = asm_q;
        for (int i = 0; i < ARG_WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                asm_nxt[i*DATA_BITS +: DATA_BITS] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_o       <= '0;
            arg_o       <= '0;
            short_stb_o <= 1'b0;
            long_stb_o  <= 1'b0;
            timeout_o   <= 1'b0;
            busy_o      <= 1'b0;
            pend_q      <= '0;
            asm_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            short_stb_o <= short_evt;
            long_stb_o  <= long_evt;
            timeout_o   <= to_evt;
            busy_o      <= (state_nxt == ARG);

            if (open_evt) begin
                pend_q <= data_i;
                asm_q  <= '0;
                idx_q  <= '0;
                cnt_q  <= '0;
            end

            if (arg_evt) begin
                asm_q <= asm_nxt;
                idx_q <= long_evt ? '0 : idx_q + 1'b1;
                cnt_q <= '0;
            end else if ((state == ARG) && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (to_evt) begin
                idx_q <= '0;
            end

            if (short_evt) begin
                cmd_o <= data_i;
            end

            if (long_evt) begin
                cmd_o <= pend_q;
                arg_o <= asm_nxt;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_sump_cmd_ctrl.sv
// Self-checking bench for sump_cmd_ctrl: directed test-plan sequences plus random
// byte streams, compared every cycle against a byte-queue reference model.
module tb_sump_cmd_ctrl;

    localparam int DB  = 8;
    localparam int CWW = 5;
    localparam int TO  = 16;
    localparam int AW  = (CWW - 1) * DB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DB-1:0] data = '0;
    logic          valid = 1'b0;
    logic [DB-1:0] cmd;
    logic [AW-1:0] arg;
    logic          short_stb;
    logic          long_stb;
    logic          timeout;
    logic          busy;
    logic          state;

    int tests_run = 0;
    int tests_failed = 0;

    sump_cmd_ctrl #(
        .DATA_BITS      (DB),
        .CMD_WIDTH_WORDS(CWW),
        .TIMEOUT_CLKS   (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_i     (data),
        .valid_i    (valid),
        .cmd_o      (cmd),
        .arg_o      (arg),
        .short_stb_o(short_stb),
        .long_stb_o (long_stb),
        .timeout_o  (timeout),
        .busy_o     (busy),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the command in progress and idle cycles since the last one.
    logic [DB-1:0] cmd_bytes[$];
    int            idle_cnt;
    logic [DB-1:0] exp_cmd;
    logic [AW-1:0] exp_arg;
    logic          exp_short;
    logic          exp_long;
    logic          exp_to;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [DB-1:0] d);
        exp_short = 1'b0;
        exp_long  = 1'b0;
        exp_to    = 1'b0;
        if (r) begin
            cmd_bytes.delete();
            idle_cnt = 0;
            exp_cmd  = '0;
            exp_arg  = '0;
        end else if (cmd_bytes.size() == 0) begin
            if (v && !d[DB-1]) begin
                exp_short = 1'b1;
                exp_cmd   = d;
            end else if (v) begin
                cmd_bytes.push_back(d);
                idle_cnt = 0;
            end
        end else if (v) begin
            cmd_bytes.push_back(d);
            idle_cnt = 0;
            if (cmd_bytes.size() == CWW) begin
                exp_long = 1'b1;
                exp_cmd  = cmd_bytes[0];
                for (int i = 1; i < CWW; i++) begin
                    exp_arg[(i-1)*DB +: DB] = cmd_bytes[i];
                end
                cmd_bytes.delete();
            end
        end else begin
            idle_cnt++;
            if (idle_cnt == TO - 1) begin
                exp_to = 1'b1;
                cmd_bytes.delete();
            end
        end
    endtask

    task automatic compare_all();
        check("cmd", 64'(cmd), 64'(exp_cmd));
        check("arg", 64'(arg), 64'(exp_arg));
        check("short_stb", 64'(short_stb), 64'(exp_short));
        check("long_stb", 64'(long_stb), 64'(exp_long));
        check("timeout", 64'(timeout), 64'(exp_to));
        check("busy", 64'(busy), 64'(cmd_bytes.size() != 0));
    endtask

    // Inputs change on the negedge, the DUT samples on posedge, outputs are checked on the next negedge.
    task automatic step(input logic r, input logic v, input logic [DB-1:0] d);
        rst   = r;
        valid = v;
        data  = d;
        @(posedge clk);
        model_step(r, v, d);
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        compare_all();
    endtask

    task automatic send(input logic [DB-1:0] d);
        step(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        cmd_bytes.delete();
        idle_cnt  = 0;
        exp_cmd   = '0;
        exp_arg   = '0;
        exp_short = 1'b0;
        exp_long  = 1'b0;
        exp_to    = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b1, 8'h85);
        step(1'b1, 1'b0, 8'h00);
        check("reset_cmd", 64'(cmd), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);

        // Short command
        send(8'h01);
        check("short_cmd_01", 64'(cmd), 64'h01);
        check("short_pulse", 64'(short_stb), 64'h1);
        idle(1);
        check("short_once", 64'(short_stb), 64'h0);

        // Long command with 10-clock gaps
        send(8'h80);
        check("busy_after_op", 64'(busy), 64'h1);
        idle(10); send(8'h11);
        idle(10); send(8'h22);
        idle(10); send(8'h33);
        idle(10); send(8'h44);
        check("long_pulse", 64'(long_stb), 64'h1);
        check("long_cmd_80", 64'(cmd), 64'h80);
        check("long_arg_1", 64'(arg), 64'h44332211);
        check("busy_fall", 64'(busy), 64'h0);
        idle(3);

        // Back-to-back long then short
        send(8'hC0); send(8'hFF); send(8'h00); send(8'hFF); send(8'h00);
        check("b2b_arg", 64'(arg), 64'h00FF00FF);
        send(8'h02);
        check("b2b_short_cmd", 64'(cmd), 64'h02);
        check("b2b_arg_hold", 64'(arg), 64'h00FF00FF);
        idle(2);

        // Timeout after one argument byte
        send(8'h81); send(8'hAA);
        idle(TO - 2);
        check("no_early_to", 64'(timeout), 64'h0);
        idle(1);
        check("timeout_pulse", 64'(timeout), 64'h1);
        check("to_busy", 64'(busy), 64'h0);
        check("to_cmd_hold", 64'(cmd), 64'h02);
        check("to_arg_hold", 64'(arg), 64'h00FF00FF);
        send(8'h00);
        check("after_to_short", 64'(cmd), 64'h00);

        // Byte on the exact expiry cycle wins
        send(8'h83);
        idle(TO - 2);
        send(8'h5A);
        check("expiry_byte_no_to", 64'(timeout), 64'h0);
        check("expiry_busy", 64'(busy), 64'h1);
        send(8'h6B); send(8'h7C); send(8'h8D);
        check("expiry_long_arg", 64'(arg), 64'h8D7C6B5A);
        check("expiry_long_cmd", 64'(cmd), 64'h83);

        // Reset mid-command
        send(8'h84); send(8'h10); send(8'h20);
        step(1'b1, 1'b0, 8'h00);
        check("rst_mid_busy", 64'(busy), 64'h0);
        check("rst_mid_arg", 64'(arg), 64'h0);
        send(8'h82); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("post_rst_arg", 64'(arg), 64'h04030201);

        // Random streams: mixed density, occasional long silences and resets
        for (int i = 0; i < 2000; i++) begin
            int roll;
            roll = $urandom_range(0, 99);
            if (roll < 1) begin
                step(1'b1, $urandom_range(0, 1) == 1, 8'($urandom));
            end else if (roll < 4) begin
                idle($urandom_range(10, 20));
            end else if (roll < 55) begin
                send(8'($urandom));
            end else begin
                step(1'b0, 1'b0, 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
